// File: rtl/ram_cmd_master.sv
// Initiator for the RAM controller command port. Requests are queued in a small FIFO and
// issued one at a time. Each result is checked against the expected op_sign and returned.
module ram_cmd_master #(
  parameter int P_MEM_SIZE = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_op,
  input  logic [31:0]           req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [3:0]            rsp_sign,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [1:0]            mem_op_code,
  output logic [P_MEM_SIZE-1:0] mem_addr,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out,
  input  logic [3:0]            mem_op_sign,
  output logic                  busy,
  output logic [CNT_W-1:0]      ok_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 35;
  localparam logic [PTR_W:0]        DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [P_MEM_SIZE-1:0] ADDR_MID = P_MEM_SIZE'(P_MEM_SIZE / 2);
  localparam logic [P_MEM_SIZE-1:0] ADDR_END = P_MEM_SIZE'(P_MEM_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  function automatic logic [P_MEM_SIZE-1:0] op_addr(input logic [1:0] op);
    case (op)
      2'd1:    return ADDR_MID;
      2'd2:    return ADDR_END;
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] exp_sign(input logic we, input logic [1:0] op);
    return we ? ({2'b00, op} + 4'd1) : ({2'b00, op} + 4'd5);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Request FIFO
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             req_ready_q;
  logic             push, pop;
  logic [ENT_W-1:0] head;
  state_e           state_q, state_d;

  assign push = req_valid && req_ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign head = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {req_we, req_op, req_data};
    end
  end

  // req_ready is registered from the post-edge occupancy, so a pop while full shows up one cycle later
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      req_ready_q <= (count_d != DEPTH_C);
    end
  end

  // Command FSM
  logic                  cmd_we_q, cmd_we_d;
  logic [1:0]            cmd_op_q, cmd_op_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [1:0]            mem_op_q, mem_op_d;
  logic [P_MEM_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_din_q, mem_din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [3:0]            rsp_sign_q, rsp_sign_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]      ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_op_d    = cmd_op_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sign_d  = rsp_sign_q;
    rsp_err_d   = rsp_err_q;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_we_d   = head[34];
          cmd_op_d   = head[33:32];
          mem_en_d   = 1'b1;
          mem_we_d   = head[34];
          mem_re_d   = !head[34];
          mem_op_d   = head[33:32];
          mem_addr_d = op_addr(head[33:32]);
          mem_din_d  = head[34] ? head[31:0] : 32'h0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        mem_op_d   = 2'd0;
        mem_addr_d = '0;
        mem_din_d  = 32'h0;
        state_d    = WAIT;
      end
      WAIT: begin
        rsp_sign_d  = mem_op_sign;
        rsp_err_d   = (mem_op_sign != exp_sign(cmd_we_q, cmd_op_q));
        rsp_data_d  = (!cmd_we_q && (cmd_op_q != 2'd3)) ? mem_data_out : 32'h0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (rsp_err_q) err_cnt_d = sat_inc(err_cnt_q);
          else           ok_cnt_d  = sat_inc(ok_cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    cmd_we_q <= cmd_we_d;
    cmd_op_q <= cmd_op_d;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_op_q    <= 2'd0;
      mem_addr_q  <= '0;
      mem_din_q   <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_sign_q  <= 4'h0;
      rsp_err_q   <= 1'b0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sign_q  <= rsp_sign_d;
      rsp_err_q   <= rsp_err_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_sign    = rsp_sign_q;
  assign rsp_err     = rsp_err_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign mem_op_code = mem_op_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_din_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign ok_cnt      = ok_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ram_cmd_master.sv
// Bench for ram_cmd_master with a simple RAM controller model attached; a second
// instance with 2-bit counters shares all inputs and checks counter saturation.
module tb_ram_cmd_master;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_data = 32'h0;
  logic [31:0] mem_data_out = 32'h0;
  logic [3:0]  mem_op_sign = 4'h0;
  logic        force_bad = 1'b0;

  logic        req_ready, rsp_valid, rsp_err, mem_en, mem_we, mem_re, busy;
  logic [31:0] rsp_data, mem_data_in;
  logic [3:0]  rsp_sign;
  logic [1:0]  mem_op_code;
  logic [7:0]  mem_addr;
  logic [15:0] ok_cnt, err_cnt;

  logic        s_req_ready, s_rsp_valid, s_rsp_err, s_mem_en, s_mem_we, s_mem_re, s_busy;
  logic [31:0] s_rsp_data, s_mem_data_in;
  logic [3:0]  s_rsp_sign;
  logic [1:0]  s_mem_op_code;
  logic [7:0]  s_mem_addr;
  logic [1:0]  s_ok_cnt, s_err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_cmd_master #(.P_MEM_SIZE(8), .FIFO_DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sign(rsp_sign), .rsp_err(rsp_err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_re(mem_re), .mem_op_code(mem_op_code), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_op_sign(mem_op_sign),
    .busy(busy), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  ram_cmd_master #(.P_MEM_SIZE(8), .FIFO_DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_op(req_op), .req_data(req_data), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(s_rsp_data), .rsp_sign(s_rsp_sign), .rsp_err(s_rsp_err), .mem_en(s_mem_en),
    .mem_we(s_mem_we), .mem_re(s_mem_re), .mem_op_code(s_mem_op_code), .mem_addr(s_mem_addr),
    .mem_data_in(s_mem_data_in), .mem_data_out(mem_data_out), .mem_op_sign(mem_op_sign),
    .busy(s_busy), .ok_cnt(s_ok_cnt), .err_cnt(s_err_cnt)
  );

  // Controller model: results registered on the edge that ends the command cycle
  logic [31:0] ctl_mem [8] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        if (mem_op_code == 2'd3) begin
          for (int i = 0; i < 8; i++) ctl_mem[i] <= mem_data_in;
        end else begin
          ctl_mem[mem_addr[2:0]] <= mem_data_in;
        end
        mem_data_out <= 32'hDEAD_BEEF;
        mem_op_sign  <= {2'b00, mem_op_code} + 4'd1;
      end else begin
        mem_data_out <= ctl_mem[mem_addr[2:0]];
        mem_op_sign  <= force_bad ? 4'd0 : ({2'b00, mem_op_code} + 4'd5);
      end
    end
  end

  int          en_cycles = 0;
  logic        last_we = 1'b0, last_re = 1'b0;
  logic [7:0]  last_addr = 8'h0;
  logic [31:0] last_din = 32'h0;
  bit          both_seen = 1'b0;
  always @(posedge clk) begin
    if (mem_en) begin
      en_cycles = en_cycles + 1;
      last_we   = mem_we;
      last_re   = mem_re;
      last_addr = mem_addr;
      last_din  = mem_data_in;
    end
    if (mem_we && mem_re) both_seen = 1'b1;
  end

  task automatic push_req(input logic we, input logic [1:0] op, input logic [31:0] d, output bit acc);
    acc = 1'b0;
    req_we = we; req_op = op; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic [3:0] s, output logic e,
                         output int lat, output bit got);
    got = 1'b0; lat = 0; d = 32'h0; s = 4'h0; e = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        d = rsp_data; s = rsp_sign; e = rsp_err; got = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    tests++; if ({req_ready, rsp_valid, mem_en, mem_we, mem_re, busy} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs: got %b required 000000", {req_ready, rsp_valid, mem_en, mem_we, mem_re, busy}); end
    tests++; if ({ok_cnt, err_cnt} !== 32'h0) begin
      fails++; $display("FAIL reset_counters: got ok=%0d err=%0d required 0/0", ok_cnt, err_cnt); end
    @(posedge clk); #1; rstN = 1'b1;
    tests++; if (req_ready !== 1'b0) begin
      fails++; $display("FAIL ready_before_edge: got %b required 0", req_ready); end
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_edge: got %b required 1", req_ready); end
  endtask

  task automatic test_write;
    logic [31:0] d; logic [3:0] s; logic e; int lat; bit acc, got; int base;
    base = en_cycles;
    push_req(1'b1, 2'd0, 32'hA5A5_0001, acc);
    get_rsp(d, s, e, lat, got);
    tests++; if (!(acc && got)) begin fails++; $display("FAIL wr0_handshake: acc=%b got=%b required 1/1", acc, got); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL wr0_latency: got %0d required 3", lat); end
    tests++; if (en_cycles - base !== 1) begin fails++; $display("FAIL wr0_en_cycles: got %0d required 1", en_cycles - base); end
    tests++; if ({last_we, last_re, last_addr, last_din} !== {1'b1, 1'b0, 8'd0, 32'hA5A5_0001}) begin
      fails++; $display("FAIL wr0_cmd: got we=%b re=%b addr=%0d din=%h required 1 0 0 a5a50001", last_we, last_re, last_addr, last_din); end
    tests++; if ({d, s, e} !== {32'h0, 4'd1, 1'b0}) begin
      fails++; $display("FAIL wr0_rsp: got data=%h sign=%0d err=%b required 0 1 0", d, s, e); end
    tests++; if (ok_cnt !== 16'd1 || s_ok_cnt !== 2'd1) begin
      fails++; $display("FAIL wr0_ok_cnt: got %0d/%0d required 1/1", ok_cnt, s_ok_cnt); end
  endtask

  task automatic test_read;
    logic [31:0] d; logic [3:0] s; logic e; int lat; bit acc, got;
    push_req(1'b0, 2'd0, 32'hFFFF_FFFF, acc);
    get_rsp(d, s, e, lat, got);
    tests++; if ({last_we, last_re, last_din} !== {1'b0, 1'b1, 32'h0}) begin
      fails++; $display("FAIL rd0_cmd: got we=%b re=%b din=%h required 0 1 0", last_we, last_re, last_din); end
    tests++; if ({got, d, s, e} !== {1'b1, 32'hA5A5_0001, 4'd5, 1'b0}) begin
      fails++; $display("FAIL rd0_rsp: got %b data=%h sign=%0d err=%b required 1 a5a50001 5 0", got, d, s, e); end
    push_req(1'b1, 2'd2, 32'h1234_5678, acc);
    get_rsp(d, s, e, lat, got);
    tests++; if ({last_addr, s, e} !== {8'd7, 4'd3, 1'b0}) begin
      fails++; $display("FAIL wr2: got addr=%0d sign=%0d err=%b required 7 3 0", last_addr, s, e); end
    push_req(1'b0, 2'd2, 32'h0, acc);
    get_rsp(d, s, e, lat, got);
    tests++; if ({last_addr, d, s, e} !== {8'd7, 32'h1234_5678, 4'd7, 1'b0}) begin
      fails++; $display("FAIL rd2: got addr=%0d data=%h sign=%0d err=%b required 7 12345678 7 0", last_addr, d, s, e); end
    tests++; if (ok_cnt !== 16'd4) begin fails++; $display("FAIL rd_ok_cnt: got %0d required 4", ok_cnt); end
  endtask

  task automatic test_err;
    logic [31:0] d; logic [3:0] s; logic e; int lat; bit acc, got;
    force_bad = 1'b1;
    push_req(1'b0, 2'd1, 32'h0, acc);
    get_rsp(d, s, e, lat, got);
    force_bad = 1'b0;
    tests++; if (last_addr !== 8'd4) begin fails++; $display("FAIL err_addr: got %0d required 4", last_addr); end
    tests++; if ({got, s, e} !== {1'b1, 4'd0, 1'b1}) begin
      fails++; $display("FAIL err_rsp: got %b sign=%0d err=%b required 1 0 1", got, s, e); end
    tests++; if ({err_cnt, ok_cnt} !== {16'd1, 16'd4}) begin
      fails++; $display("FAIL err_cnts: got err=%0d ok=%0d required 1 4", err_cnt, ok_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic [3:0] s; logic e; int lat; bit acc, got; bit all_acc;
    logic        we_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  op_v [5] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd3};
    logic [31:0] dat_v[5] = '{32'hCAFE_0004, 32'h0, 32'h0BAD_0000, 32'h0, 32'h0};
    logic [31:0] exp_d[5] = '{32'h0, 32'hCAFE_0004, 32'h0, 32'h0BAD_0000, 32'h0};
    logic [3:0]  exp_s[5] = '{4'd2, 4'd6, 4'd1, 4'd5, 4'd8};
    all_acc = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_req(we_v[i], op_v[i], dat_v[i], acc);
      all_acc = all_acc & acc;
    end
    tests++; if (all_acc !== 1'b1) begin fails++; $display("FAIL bp_accept5: got %b required 1", all_acc); end
    tests++; if ({req_ready, rsp_valid, busy} !== 3'b011) begin
      fails++; $display("FAIL bp_full: got ready/valid/busy=%b required 011", {req_ready, rsp_valid, busy}); end
    push_req(1'b1, 2'd2, 32'h6666_6666, acc);
    tests++; if (acc !== 1'b0) begin fails++; $display("FAIL bp_sixth_blocked: got accepted=%b required 0", acc); end
    for (int i = 0; i < 5; i++) begin
      get_rsp(d, s, e, lat, got);
      tests++; if ({got, d, s, e} !== {1'b1, exp_d[i], exp_s[i], 1'b0}) begin
        fails++; $display("FAIL bp_rsp%0d: got %b data=%h sign=%0d err=%b required 1 %h %0d 0", i, got, d, s, e, exp_d[i], exp_s[i]); end
    end
    tests++; if ({ok_cnt, err_cnt} !== {16'd9, 16'd1}) begin
      fails++; $display("FAIL bp_cnts: got ok=%0d err=%0d required 9 1", ok_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic [3:0] s; logic e; int lat; bit acc, got;
    push_req(1'b0, 2'd0, 32'h0, acc);
    push_req(1'b1, 2'd1, 32'h0000_0099, acc);
    @(posedge clk); #1;
    #2 rstN = 1'b0;
    #1;
    tests++; if ({mem_en, rsp_valid, busy, req_ready} !== 4'b0) begin
      fails++; $display("FAIL rstwait_outputs: got en/valid/busy/ready=%b required 0000", {mem_en, rsp_valid, busy, req_ready}); end
    tests++; if ({ok_cnt, err_cnt} !== 32'h0) begin
      fails++; $display("FAIL rstwait_counters: got ok=%0d err=%0d required 0 0", ok_cnt, err_cnt); end
    @(posedge clk); #1; rstN = 1'b1;
    @(posedge clk); #1;
    tests++; if ({busy, rsp_valid, req_ready} !== 3'b001) begin
      fails++; $display("FAIL rstwait_empty: got busy/valid/ready=%b required 001", {busy, rsp_valid, req_ready}); end
    push_req(1'b1, 2'd1, 32'h0000_0077, acc);
    get_rsp(d, s, e, lat, got);
    tests++; if ({got, lat, s, e} !== {1'b1, 32'd3, 4'd2, 1'b0}) begin
      fails++; $display("FAIL rstwait_next: got %b lat=%0d sign=%0d err=%b required 1 3 2 0", got, lat, s, e); end
    repeat (3) @(posedge clk); #1;
    tests++; if ({busy, rsp_valid, ok_cnt} !== {1'b0, 1'b0, 16'd1}) begin
      fails++; $display("FAIL rstwait_after: got busy=%b valid=%b ok=%0d required 0 0 1", busy, rsp_valid, ok_cnt); end
  endtask

  task automatic test_reset_issue;
    bit acc;
    push_req(1'b1, 2'd2, 32'h0000_0011, acc);
    @(posedge clk); #1;
    tests++; if ({mem_en, mem_we} !== 2'b11) begin
      fails++; $display("FAIL rstiss_pre: got en/we=%b required 11", {mem_en, mem_we}); end
    rstN = 1'b0;
    #1;
    tests++; if ({mem_en, mem_we, mem_addr, mem_data_in} !== 42'h0) begin
      fails++; $display("FAIL rstiss_async: got en=%b we=%b addr=%0d din=%h required all 0", mem_en, mem_we, mem_addr, mem_data_in); end
    @(posedge clk); #1; rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sat;
    logic [31:0] d; logic [3:0] s; logic e; int lat; bit acc, got;
    for (int i = 0; i < 4; i++) begin
      push_req(1'b1, 2'd3, 32'h5555_AAAA, acc);
      get_rsp(d, s, e, lat, got);
      tests++; if ({got, last_addr, s, e} !== {1'b1, 8'd0, 4'd4, 1'b0}) begin
        fails++; $display("FAIL whole_wr%0d: got %b addr=%0d sign=%0d err=%b required 1 0 4 0", i, got, last_addr, s, e); end
    end
    push_req(1'b0, 2'd3, 32'h0, acc);
    get_rsp(d, s, e, lat, got);
    tests++; if ({got, d, s, e} !== {1'b1, 32'h0, 4'd8, 1'b0}) begin
      fails++; $display("FAIL whole_rd: got %b data=%h sign=%0d err=%b required 1 0 8 0", got, d, s, e); end
    tests++; if ({ok_cnt, err_cnt} !== {16'd5, 16'd0}) begin
      fails++; $display("FAIL sat_wide: got ok=%0d err=%0d required 5 0", ok_cnt, err_cnt); end
    tests++; if (s_ok_cnt !== 2'd3) begin fails++; $display("FAIL sat_ok_cnt: got %0d required 3", s_ok_cnt); end
    tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL we_re_both: got %b required 0", both_seen); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_err;
    test_back_to_back;
    test_reset_mid;
    test_reset_issue;
    test_sat;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
